// File: rtl/spio_spinnaker_link_pkt_checker_pkg.sv
// Shared packet definitions for the SpiNNaker link packet path.
//   PKT_W              : width of one link packet (72 bits)
//   PKT_*_MSB/LSB      : field ranges {pld[71:40], key[39:8], hdr[7:0]}
//   HDR_PLD_BIT        : header bit flagging that the payload word is present
//   HDR_PRTY_BIT       : header bit carrying the odd-parity bit
//   occ_t              : occupancy states of the 2-entry skid buffer
//   pkt_parity_ok(pkt) : 1 when the packet carries correct odd parity
package spio_pkt_defs;

    localparam int unsigned PKT_W       = 72;

    localparam int unsigned PKT_HDR_MSB = 7;
    localparam int unsigned PKT_HDR_LSB = 0;
    localparam int unsigned PKT_KEY_MSB = 39;
    localparam int unsigned PKT_KEY_LSB = 8;
    localparam int unsigned PKT_PLD_MSB = 71;
    localparam int unsigned PKT_PLD_LSB = 40;

    localparam int unsigned HDR_PLD_BIT  = 1;
    localparam int unsigned HDR_PRTY_BIT = 0;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_TWO
    } occ_t;

    // Payload bits only take part in the check when the header says a
    // payload is present; otherwise they are don't-care.
    function automatic logic pkt_parity_ok(input logic [PKT_W-1:0] pkt);
        logic p;
        p = pkt[HDR_PRTY_BIT]
            ^ (^pkt[PKT_HDR_MSB:HDR_PRTY_BIT+1])
            ^ (^pkt[PKT_KEY_MSB:PKT_KEY_LSB]);
        if (pkt[HDR_PLD_BIT]) begin
            p = p ^ (^pkt[PKT_PLD_MSB:PKT_PLD_LSB]);
        end
        return p;
    endfunction

endpackage

// File: rtl/spio_spinnaker_link_pkt_checker_if.sv
// Valid/ready packet bus interfaces used at the packet checker boundary.
//   spio_pkt_in_if  : data[71:0], vld (master->slave), rdy (slave->master)
//   spio_pkt_out_if : as above plus err, a parity-error tag qualified by vld
interface spio_pkt_in_if;
    import spio_pkt_defs::*;

    logic [PKT_W-1:0] data;
    logic             vld;
    logic             rdy;

    modport master (output data, output vld, input  rdy);
    modport slave  (input  data, input  vld, output rdy);
endinterface

interface spio_pkt_out_if;
    import spio_pkt_defs::*;

    logic [PKT_W-1:0] data;
    logic             err;
    logic             vld;
    logic             rdy;

    modport master (output data, output err, output vld, input  rdy);
    modport slave  (input  data, input  err, input  vld, output rdy);
endinterface

// File: rtl/spio_spinnaker_link_pkt_checker_skid_buffer.sv
// Two-entry skid buffer with fully registered handshake outputs.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_data    : word to store, in_push : store it this cycle (caller has
//                already qualified it with in_rdy)
//   in_rdy     : registered, high while the next occupancy is not TWO
//   out_data   : head word (main register), out_vld : registered valid
//   out_rdy    : downstream ready; a pop happens on out_vld && out_rdy
module spio_pkt_skid_buffer
    import spio_pkt_defs::*;
#(
    parameter int unsigned W = 73
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_push,
    output logic         in_rdy,
    output logic [W-1:0] out_data,
    output logic         out_vld,
    input  logic         out_rdy
);

    occ_t         state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         vld_q, vld_d;
    logic         rdy_q, rdy_d;
    logic         pop;

    always_comb begin
        pop     = vld_q && out_rdy;
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            OCC_EMPTY: begin
                if (in_push) begin
                    main_d  = in_data;
                    state_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (in_push && pop) begin
                    main_d = in_data;
                end else if (in_push) begin
                    skid_d  = in_data;
                    state_d = OCC_TWO;
                end else if (pop) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = OCC_ONE;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
        // Both handshake outputs are decoded from the next state so that
        // they come straight from flops and out_rdy never reaches in_rdy.
        vld_d = (state_d != OCC_EMPTY);
        rdy_d = (state_d != OCC_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OCC_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            vld_q   <= vld_d;
            rdy_q   <= rdy_d;
        end
    end

    assign in_rdy   = rdy_q;
    assign out_data = main_q;
    assign out_vld  = vld_q;

endmodule

// File: rtl/spio_spinnaker_link_pkt_checker.sv
// Packet integrity stage after the SpiNNaker link receiver: checks odd
// parity, drops (DROP_BAD=1) or tags (DROP_BAD=0) bad packets, keeps
// saturating good/bad counters and re-times the handshake via a skid buffer.
//   CLK_IN, RESET_IN : clock, asynchronous active-low reset
//   PKT_IN           : input packet bus (slave), rdy is registered
//   PKT_OUT          : output packet bus (master), vld is registered, err
//                      tags parity errors (always 0 when DROP_BAD=1)
//   CNT_CLR_IN       : synchronous clear of both counters (beats increment)
//   GOOD_CNT_OUT     : accepted packets with correct parity
//   BAD_CNT_OUT      : accepted packets with parity error
module spio_spinnaker_link_pkt_checker
    import spio_pkt_defs::*;
#(
    parameter bit          DROP_BAD  = 1'b1,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 CLK_IN,
    input  logic                 RESET_IN,
    spio_pkt_in_if.slave         PKT_IN,
    spio_pkt_out_if.master       PKT_OUT,
    input  logic                 CNT_CLR_IN,
    output logic [CNT_WIDTH-1:0] GOOD_CNT_OUT,
    output logic [CNT_WIDTH-1:0] BAD_CNT_OUT
);

    logic                 in_rdy;
    logic                 accept;
    logic                 parity_ok;
    logic                 pkt_err;
    logic                 push;
    logic [PKT_W:0]       buf_out;
    logic                 buf_vld;
    logic [CNT_WIDTH-1:0] good_cnt_q, good_cnt_d;
    logic [CNT_WIDTH-1:0] bad_cnt_q, bad_cnt_d;

    always_comb begin
        parity_ok = pkt_parity_ok(PKT_IN.data);
        accept    = PKT_IN.vld && in_rdy;
        pkt_err   = DROP_BAD ? 1'b0 : !parity_ok;
        // A dropped packet still completes its handshake but never enters
        // the buffer.
        push      = accept && (parity_ok || !DROP_BAD);
    end

    always_comb begin
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        if (accept && parity_ok && (good_cnt_q != '1)) begin
            good_cnt_d = good_cnt_q + CNT_WIDTH'(1);
        end
        if (accept && !parity_ok && (bad_cnt_q != '1)) begin
            bad_cnt_d = bad_cnt_q + CNT_WIDTH'(1);
        end
        if (CNT_CLR_IN) begin
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end
    end

    always_ff @(posedge CLK_IN or negedge RESET_IN) begin
        if (!RESET_IN) begin
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    spio_pkt_skid_buffer #(
        .W (PKT_W + 1)
    ) u_skid (
        .clk      (CLK_IN),
        .rst_n    (RESET_IN),
        .in_data  ({pkt_err, PKT_IN.data}),
        .in_push  (push),
        .in_rdy   (in_rdy),
        .out_data (buf_out),
        .out_vld  (buf_vld),
        .out_rdy  (PKT_OUT.rdy)
    );

    assign PKT_IN.rdy   = in_rdy;
    assign PKT_OUT.data = buf_out[PKT_W-1:0];
    assign PKT_OUT.err  = buf_out[PKT_W];
    assign PKT_OUT.vld  = buf_vld;

    assign GOOD_CNT_OUT = good_cnt_q;
    assign BAD_CNT_OUT  = bad_cnt_q;

endmodule

// File: tb/tb_spio_spinnaker_link_pkt_checker.sv
// Two instances share one stimulus stream: dut_a drops bad packets with a
// 4-bit counter, dut_b tags them with a 16-bit counter.
module tb_spio_spinnaker_link_pkt_checker;
    import spio_pkt_defs::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic clr;
    logic rdy_in;
    bit   rnd_rdy;

    logic [3:0]  good_a, bad_a;
    logic [15:0] good_b, bad_b;

    spio_pkt_in_if  in_a ();
    spio_pkt_in_if  in_b ();
    spio_pkt_out_if out_a ();
    spio_pkt_out_if out_b ();

    assign out_a.rdy = rdy_in;
    assign out_b.rdy = rdy_in;

    spio_spinnaker_link_pkt_checker #(.DROP_BAD(1'b1), .CNT_WIDTH(4)) dut_a (
        .CLK_IN(clk), .RESET_IN(rst_n), .PKT_IN(in_a), .PKT_OUT(out_a),
        .CNT_CLR_IN(clr), .GOOD_CNT_OUT(good_a), .BAD_CNT_OUT(bad_a));

    spio_spinnaker_link_pkt_checker #(.DROP_BAD(1'b0), .CNT_WIDTH(16)) dut_b (
        .CLK_IN(clk), .RESET_IN(rst_n), .PKT_IN(in_b), .PKT_OUT(out_b),
        .CNT_CLR_IN(clr), .GOOD_CNT_OUT(good_b), .BAD_CNT_OUT(bad_b));

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: expected output words {err, pkt} and counters.
    logic [72:0] exp_a[$];
    logic [72:0] exp_b[$];
    int          good_m[2];
    int          bad_m[2];
    int          lim[2] = '{15, 65535};
    bit          pend[2];
    logic [71:0] cur;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Odd parity over header, key and (if flagged) payload, by bit count.
    function automatic bit is_good(input logic [71:0] p);
        int ones;
        ones = $countones(p[7:0]) + $countones(p[39:8]);
        if (p[1]) ones += $countones(p[71:40]);
        return (ones % 2) == 1;
    endfunction

    function automatic logic [71:0] make_pkt(input bit good, input bit has_pld);
        logic [31:0] key, pld;
        logic [7:0]  hdr;
        int          ones;
        key    = $urandom;
        pld    = $urandom;
        hdr    = 8'($urandom);
        hdr[1] = has_pld;
        ones   = $countones(hdr[7:1]) + $countones(key) + (has_pld ? $countones(pld) : 0);
        hdr[0] = (((ones % 2) == 0) == good);
        return {pld, key, hdr};
    endfunction

    function automatic logic in_rdy_of(input int d);
        return (d == 0) ? in_a.rdy : in_b.rdy;
    endfunction

    task automatic model_accept(input int d, input logic [71:0] p);
        bit g;
        g = is_good(p);
        if (g) begin
            if (good_m[d] < lim[d]) good_m[d]++;
        end else begin
            if (bad_m[d] < lim[d]) bad_m[d]++;
        end
        if (d == 0) begin
            if (g) exp_a.push_back({1'b0, p});
        end else begin
            exp_b.push_back({~g, p});
        end
    endtask

    // One clock: record handshakes seen before the edge, then update inputs.
    task automatic step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (pend[d] && in_rdy_of(d) === 1'b1) begin
                model_accept(d, cur);
                pend[d] = 1'b0;
            end
        end
        if (clr) begin
            good_m = '{0, 0};
            bad_m  = '{0, 0};
        end
        @(posedge clk);
        #1;
        in_a.vld = pend[0];
        in_b.vld = pend[1];
        clr      = 1'b0;
    endtask

    task automatic present(input logic [71:0] p, input bit with_clr);
        cur       = p;
        in_a.data = p;
        in_b.data = p;
        pend      = '{1'b1, 1'b1};
        in_a.vld  = 1'b1;
        in_b.vld  = 1'b1;
        clr       = with_clr;
    endtask

    task automatic wait_accept(input int budget, input string name);
        int n;
        n = 0;
        while ((pend[0] || pend[1]) && n < budget) begin
            step();
            n++;
        end
        if (pend[0] || pend[1]) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: still pending after %0d cycles, expected accept", name, budget);
            pend     = '{1'b0, 1'b0};
            in_a.vld = 1'b0;
            in_b.vld = 1'b0;
        end
    endtask

    task automatic drain(input int n);
        repeat (n) step();
    endtask

    task automatic check_cnts(input string name);
        chk({name, "_good_a"}, good_a, good_m[0]);
        chk({name, "_bad_a"},  bad_a,  bad_m[0]);
        chk({name, "_good_b"}, good_b, good_m[1]);
        chk({name, "_bad_b"},  bad_b,  bad_m[1]);
    endtask

    // Scoreboard monitors: a transfer happens at the next posedge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_a.vld === 1'b1 && out_a.rdy === 1'b1) begin
            if (exp_a.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL out_a_unexpected: got %0h, expected no packet", {out_a.err, out_a.data});
            end else begin
                logic [72:0] e;
                e = exp_a.pop_front();
                chk("out_a", {out_a.err, out_a.data}, e);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_b.vld === 1'b1 && out_b.rdy === 1'b1) begin
            if (exp_b.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL out_b_unexpected: got %0h, expected no packet", {out_b.err, out_b.data});
            end else begin
                logic [72:0] e;
                e = exp_b.pop_front();
                chk("out_b", {out_b.err, out_b.data}, e);
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (rnd_rdy) rdy_in = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic [71:0] p1;
        rst_n     = 1'b0;
        clr       = 1'b0;
        rdy_in    = 1'b0;
        rnd_rdy   = 1'b0;
        in_a.vld  = 1'b0;
        in_b.vld  = 1'b0;
        in_a.data = '0;
        in_b.data = '0;
        pend      = '{1'b0, 1'b0};
        good_m    = '{0, 0};
        bad_m     = '{0, 0};

        // Reset state
        #12;
        chk("rst_rdy_a", in_a.rdy, 0);
        chk("rst_vld_a", out_a.vld, 0);
        chk("rst_err_a", out_a.err, 0);
        chk("rst_data_a", out_a.data, 0);
        chk("rst_rdy_b", in_b.rdy, 0);
        chk("rst_vld_b", out_b.vld, 0);
        chk("rst_data_b", out_b.data, 0);
        check_cnts("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_rdy_a", in_a.rdy, 1);
        chk("rel_rdy_b", in_b.rdy, 1);
        rdy_in = 1'b1;

        // Good packet without payload, one-cycle latency
        present(72'h0_00000001_00, 1'b0);
        wait_accept(20, "t1");
        chk("t1_vld_a", out_a.vld, 1);
        chk("t1_vld_b", out_b.vld, 1);
        drain(4);
        check_cnts("t1");

        // Payload packet good, then same with bad header
        present({32'ha5a5a5a5, 32'h00000001, 8'h03}, 1'b0);
        wait_accept(20, "t2a");
        drain(4);
        present({32'ha5a5a5a5, 32'h00000001, 8'h02}, 1'b0);
        wait_accept(20, "t2b");
        chk("t2_drop_vld_a", out_a.vld, 0);
        chk("t2_tag_vld_b", out_b.vld, 1);
        drain(4);
        check_cnts("t2");

        // Bad packet without payload
        present({32'h0, 32'h00000001, 8'h01}, 1'b0);
        wait_accept(20, "t3");
        drain(4);
        check_cnts("t3");

        // Backpressure: two fill the buffer, third waits
        rdy_in = 1'b0;
        p1 = make_pkt(1'b1, 1'b1);
        present(p1, 1'b0);
        wait_accept(20, "t4p1");
        present(make_pkt(1'b1, 1'b0), 1'b0);
        wait_accept(20, "t4p2");
        chk("t4_full_rdy_a", in_a.rdy, 0);
        chk("t4_full_rdy_b", in_b.rdy, 0);
        present(make_pkt(1'b1, 1'b1), 1'b0);
        repeat (3) step();
        chk("t4_held_rdy_a", in_a.rdy, 0);
        chk("t4_held_data_a", out_a.data, p1);
        chk("t4_held_vld_b", out_b.vld, 1);
        rdy_in = 1'b1;
        wait_accept(20, "t4p3");
        drain(6);
        check_cnts("t4");

        // Saturation and clear-wins
        clr = 1'b1;
        step();
        for (int i = 0; i < 17; i++) begin
            present(make_pkt(1'b1, 1'($urandom_range(0, 1))), 1'b0);
            wait_accept(20, "t5");
        end
        drain(4);
        chk("t5_sat_a", good_a, 4'hF);
        check_cnts("t5");
        present(make_pkt(1'b1, 1'b0), 1'b1);
        wait_accept(20, "t5clr");
        drain(4);
        check_cnts("t5clr");

        // Async reset with two entries held
        rdy_in = 1'b0;
        present(make_pkt(1'b1, 1'b1), 1'b0);
        wait_accept(20, "t6p1");
        present(make_pkt(1'b1, 1'b0), 1'b0);
        wait_accept(20, "t6p2");
        chk("t6_full_rdy_a", in_a.rdy, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_vld_a", out_a.vld, 0);
        chk("t6_rst_rdy_a", in_a.rdy, 0);
        chk("t6_rst_vld_b", out_b.vld, 0);
        chk("t6_rst_rdy_b", in_b.rdy, 0);
        exp_a.delete();
        exp_b.delete();
        good_m = '{0, 0};
        bad_m  = '{0, 0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rdy_in = 1'b1;
        chk("t6_rel_rdy_b", in_b.rdy, 1);
        drain(6);
        check_cnts("t6");

        // Randomized traffic with random backpressure and occasional clears
        rnd_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) step();
            present(make_pkt($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1))),
                    $urandom_range(0, 19) == 0);
            wait_accept(200, "rnd");
        end
        rnd_rdy = 1'b0;
        step();
        rdy_in = 1'b1;
        drain(20);
        check_cnts("rnd");
        chk("rnd_left_a", exp_a.size(), 0);
        chk("rnd_left_b", exp_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
